// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg
// Shared definitions for the main-memory arbiter and its helpers:
//   arb_state_t  - arbiter grant states
//   BLOCK_BEATS  - words per cache block fill
//   MEM_ADDR_W   - main-memory address width
//   MEM_DATA_W   - main-memory data word width
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_FILL = 2'd1,
        ARB_D_FILL = 2'd2,
        ARB_WRITE  = 2'd3
    } arb_state_t;

    localparam int BLOCK_BEATS = 8;
    localparam int MEM_ADDR_W  = 16;
    localparam int MEM_DATA_W  = 16;

endpackage

// File: rtl/cache_mem_arbiter_beat_counter.sv
// beat_counter
// Synchronous clear/increment counter with a terminal-count flag. Used by
// the arbiter to count returning fill beats; equally usable by a fill FSM.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   clear    - force the count to zero (wins over inc)
//   inc      - advance the count by one, wrapping past MAX
//   tc       - high while the count equals MAX
module beat_counter #(
    parameter int          WIDTH = 3,
    parameter int unsigned MAX   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = (count_q == WIDTH'(MAX)) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == WIDTH'(MAX));

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares the single main-memory port between the I-cache fill FSM, the
// D-cache fill FSM and D-cache write-through stores. A fill grant is held
// for a whole block so each fill FSM only ever sees its own beats.
// Ports:
//   clk, rst                   - clock, synchronous active-high reset
//   i_req, i_addr              - I-fill request (busy) and memory address
//   d_req, d_addr              - D-fill request (busy) and memory address
//   wr_req, wr_addr, wr_data   - write-through store request
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                  - memory command port
//   mem_valid                  - memory read data valid
//   i_valid, d_valid           - data-valid routed to the granted fill FSM
//   wr_ack                     - store accepted (one-cycle pulse)
//   wr_stall                   - store pending but not yet accepted
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int BEATS  = BLOCK_BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_valid,
    output logic              i_valid,
    output logic              d_valid,
    output logic              wr_ack,
    output logic              wr_stall
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_fill_was_d_q;
    logic       last_fill_was_d_d;

    logic filling;
    logic beat_inc;
    logic beat_tc;
    logic final_beat;

    // The counter sits at zero whenever no fill is granted, which gives the
    // clear-on-entry behaviour without a separate entry pulse.
    assign filling    = (state_q == ARB_I_FILL) || (state_q == ARB_D_FILL);
    assign beat_inc   = filling && mem_valid;
    assign final_beat = beat_inc && beat_tc;

    beat_counter #(
        .WIDTH (CNT_W),
        .MAX   (BEATS - 1)
    ) u_beat_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (!filling),
        .inc   (beat_inc),
        .tc    (beat_tc)
    );

    // Next-state: stores win in IDLE, contending fills alternate using the
    // last_fill_was_d flag, and a fill grant is only released on its final beat.
    always_comb begin
        state_d           = state_q;
        last_fill_was_d_d = last_fill_was_d_q;
        case (state_q)
            ARB_IDLE: begin
                if (wr_req) begin
                    state_d = ARB_WRITE;
                end else if (i_req && d_req) begin
                    state_d = last_fill_was_d_q ? ARB_I_FILL : ARB_D_FILL;
                end else if (i_req) begin
                    state_d = ARB_I_FILL;
                end else if (d_req) begin
                    state_d = ARB_D_FILL;
                end
            end
            ARB_WRITE: begin
                state_d = ARB_IDLE;
            end
            ARB_I_FILL: begin
                if (final_beat) begin
                    state_d           = ARB_IDLE;
                    last_fill_was_d_d = 1'b0;
                end
            end
            ARB_D_FILL: begin
                if (final_beat) begin
                    state_d           = ARB_IDLE;
                    last_fill_was_d_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ARB_IDLE;
            last_fill_was_d_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            last_fill_was_d_q <= last_fill_was_d_d;
        end
    end

    // Memory port and valid routing are decoded straight from the state, so
    // mem_valid reaches only the granted fill FSM and is dropped otherwise.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_valid   = 1'b0;
        d_valid   = 1'b0;
        wr_ack    = 1'b0;
        case (state_q)
            ARB_WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                wr_ack    = 1'b1;
            end
            ARB_I_FILL: begin
                mem_en   = 1'b1;
                mem_addr = i_addr;
                i_valid  = mem_valid;
            end
            ARB_D_FILL: begin
                mem_en   = 1'b1;
                mem_addr = d_addr;
                d_valid  = mem_valid;
            end
            default: begin
            end
        endcase
    end

    assign wr_stall = wr_req && !wr_ack;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Directed bench for cache_mem_arbiter: a table of single-cycle vectors for
// reset, stray valids, write priority and reset mid-fill, followed by
// hand-written multi-cycle block fills, write-during-fill and contention.
module tb_cache_mem_arbiter;

    typedef struct packed {
        logic        mem_en;
        logic        mem_wr;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        i_valid;
        logic        d_valid;
        logic        wr_ack;
        logic        wr_stall;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        i_req;
        logic [15:0] i_addr;
        logic        d_req;
        logic [15:0] d_addr;
        logic        wr_req;
        logic [15:0] wr_addr;
        logic [15:0] wr_data;
        logic        mem_valid;
        logic        chk;
        out_t        exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic [15:0] d_addr;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_valid;
    logic        i_valid;
    logic        d_valid;
    logic        wr_ack;
    logic        wr_stall;

    int checks = 0;
    int errors = 0;

    logic [15:0] i_base;
    logic [15:0] d_base;
    int          i_cnt;
    int          d_cnt;

    vec_t vecs[14];

    cache_mem_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .BEATS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .i_valid   (i_valid),
        .d_valid   (d_valid),
        .wr_ack    (wr_ack),
        .wr_stall  (wr_stall)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic out_t mk_out(input logic en, input logic wr, input logic [15:0] addr,
                                    input logic [15:0] wdata, input logic iv, input logic dv,
                                    input logic ack, input logic stall);
        out_t o;
        o.mem_en    = en;
        o.mem_wr    = wr;
        o.mem_addr  = addr;
        o.mem_wdata = wdata;
        o.i_valid   = iv;
        o.d_valid   = dv;
        o.wr_ack    = ack;
        o.wr_stall  = stall;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic r, input logic ir, input logic [15:0] ia,
                                    input logic dr, input logic [15:0] da, input logic wq,
                                    input logic [15:0] wa, input logic [15:0] wd,
                                    input logic mv, input logic chk, input out_t exp);
        vec_t v;
        v.rst       = r;
        v.i_req     = ir;
        v.i_addr    = ia;
        v.d_req     = dr;
        v.d_addr    = da;
        v.wr_req    = wq;
        v.wr_addr   = wa;
        v.wr_data   = wd;
        v.mem_valid = mv;
        v.chk       = chk;
        v.exp       = exp;
        return v;
    endfunction

    // Inputs change 1 time unit after the rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        nextCycle();
        rst       = v.rst;
        i_req     = v.i_req;
        i_addr    = v.i_addr;
        d_req     = v.d_req;
        d_addr    = v.d_addr;
        wr_req    = v.wr_req;
        wr_addr   = v.wr_addr;
        wr_data   = v.wr_data;
        mem_valid = v.mem_valid;
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        @(negedge clk);
        act = {mem_en, mem_wr, mem_addr, mem_wdata, i_valid, d_valid, wr_ack, wr_stall};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got en=%b wr=%b addr=%h wdata=%h iv=%b dv=%b ack=%b stall=%b, expected en=%b wr=%b addr=%h wdata=%h iv=%b dv=%b ack=%b stall=%b",
                     name, act.mem_en, act.mem_wr, act.mem_addr, act.mem_wdata, act.i_valid,
                     act.d_valid, act.wr_ack, act.wr_stall, exp.mem_en, exp.mem_wr, exp.mem_addr,
                     exp.mem_wdata, exp.i_valid, exp.d_valid, exp.wr_ack, exp.wr_stall);
        end
    endtask

    // Runs one granted block fill, starting in the first granted cycle.
    // Memory answers every 'spacing' cycles; the requester bumps its address
    // the cycle after each beat. Ends with the IDLE cycle after beat 8, in
    // which the granted requester drops its request unless keep_req is set.
    task automatic runFill(input bit is_d, input int spacing, input bit raise_wr, input bit keep_req);
        bit          bump;
        logic [15:0] exp_addr;
        bump = 1'b0;
        for (int beat = 0; beat < 8; beat++) begin
            for (int c = 0; c < spacing; c++) begin
                nextCycle();
                if (bump) begin
                    if (is_d) d_cnt++;
                    else i_cnt++;
                end
                i_addr    = i_base + 16'(i_cnt);
                d_addr    = d_base + 16'(d_cnt);
                mem_valid = (c == spacing - 1);
                if (raise_wr && beat == 3 && c == 0) wr_req = 1'b1;
                exp_addr  = is_d ? d_base + 16'(d_cnt) : i_base + 16'(i_cnt);
                checkOutput($sformatf("%s_fill_beat%0d_cyc%0d", is_d ? "d" : "i", beat, c),
                            mk_out(1'b1, 1'b0, exp_addr, 16'h0000, mem_valid && !is_d,
                                   mem_valid && is_d, 1'b0, wr_req));
                bump = mem_valid;
            end
        end
        nextCycle();
        if (is_d) d_cnt++;
        else i_cnt++;
        i_addr    = i_base + 16'(i_cnt);
        d_addr    = d_base + 16'(d_cnt);
        mem_valid = 1'b0;
        if (!keep_req) begin
            if (is_d) d_req = 1'b0;
            else i_req = 1'b0;
        end
        checkOutput($sformatf("%s_fill_idle_after", is_d ? "d" : "i"),
                    mk_out(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, wr_req));
    endtask

    initial begin
        out_t zero;
        zero = mk_out(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = 16'h0000;
        d_req     = 1'b0;
        d_addr    = 16'h0000;
        wr_req    = 1'b0;
        wr_addr   = 16'h0000;
        wr_data   = 16'h0000;
        mem_valid = 1'b0;
        i_base    = 16'h0000;
        d_base    = 16'h0000;
        i_cnt     = 0;
        d_cnt     = 0;

        // Reset, stray valid in IDLE, write priority over a D-fill, then a
        // D-fill reset after beat 4 followed by two stray beats.
        vecs[0]  = mk_vec(1, 0, 16'h0F00, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, zero);
        vecs[1]  = mk_vec(1, 0, 16'h0F00, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, zero);
        vecs[2]  = mk_vec(0, 0, 16'h0F00, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1, zero);
        vecs[3]  = mk_vec(0, 0, 16'h0F00, 1, 16'h0200, 1, 16'h1234, 16'hBEEF, 0, 1,
                          mk_out(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1));
        vecs[4]  = mk_vec(0, 0, 16'h0F00, 1, 16'h0200, 1, 16'h1234, 16'hBEEF, 0, 1,
                          mk_out(1, 1, 16'h1234, 16'hBEEF, 0, 0, 1, 0));
        vecs[5]  = mk_vec(0, 0, 16'h0F00, 1, 16'h0200, 0, 16'h1234, 16'hBEEF, 0, 1, zero);
        vecs[6]  = mk_vec(0, 0, 16'h0F00, 1, 16'h0200, 0, 16'h1234, 16'hBEEF, 0, 1,
                          mk_out(1, 0, 16'h0200, 16'h0000, 0, 0, 0, 0));
        vecs[7]  = mk_vec(0, 0, 16'h0F00, 1, 16'h0200, 0, 16'h1234, 16'hBEEF, 1, 1,
                          mk_out(1, 0, 16'h0200, 16'h0000, 0, 1, 0, 0));
        vecs[8]  = mk_vec(0, 0, 16'h0F00, 1, 16'h0201, 0, 16'h1234, 16'hBEEF, 1, 1,
                          mk_out(1, 0, 16'h0201, 16'h0000, 0, 1, 0, 0));
        vecs[9]  = mk_vec(0, 0, 16'h0F00, 1, 16'h0202, 0, 16'h1234, 16'hBEEF, 1, 1,
                          mk_out(1, 0, 16'h0202, 16'h0000, 0, 1, 0, 0));
        vecs[10] = mk_vec(0, 0, 16'h0F00, 1, 16'h0203, 0, 16'h1234, 16'hBEEF, 1, 1,
                          mk_out(1, 0, 16'h0203, 16'h0000, 0, 1, 0, 0));
        vecs[11] = mk_vec(1, 0, 16'h0F00, 1, 16'h0204, 0, 16'h1234, 16'hBEEF, 0, 1,
                          mk_out(1, 0, 16'h0204, 16'h0000, 0, 0, 0, 0));
        vecs[12] = mk_vec(0, 0, 16'h0F00, 0, 16'h0204, 0, 16'h1234, 16'hBEEF, 1, 1, zero);
        vecs[13] = mk_vec(0, 0, 16'h0F00, 0, 16'h0204, 0, 16'h1234, 16'hBEEF, 1, 1, zero);

        for (int k = 0; k < 14; k++) begin
            applyStimulus(vecs[k]);
            if (vecs[k].chk) checkOutput($sformatf("vec%0d", k), vecs[k].exp);
        end

        // D-fill after the mid-fill reset must run a full 8 beats again.
        nextCycle();
        mem_valid = 1'b0;
        wr_req    = 1'b0;
        d_base    = 16'h0300;
        d_cnt     = 0;
        d_addr    = d_base;
        d_req     = 1'b1;
        checkOutput("d_after_reset_bubble", zero);
        runFill(1'b1, 2, 1'b0, 1'b0);

        // Single I-fill at 0x0040, 4-cycle memory spacing.
        nextCycle();
        i_base = 16'h0040;
        i_cnt  = 0;
        i_addr = i_base;
        i_req  = 1'b1;
        checkOutput("i_single_bubble", zero);
        runFill(1'b0, 4, 1'b0, 1'b0);

        // Store raised at beat 3 of an I-fill stalls until the fill ends.
        nextCycle();
        wr_addr = 16'h0ABC;
        wr_data = 16'h5A5A;
        i_base  = 16'h0080;
        i_cnt   = 0;
        i_addr  = i_base;
        i_req   = 1'b1;
        checkOutput("wr_during_fill_bubble", zero);
        runFill(1'b0, 1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("wr_after_fill_write", mk_out(1, 1, 16'h0ABC, 16'h5A5A, 0, 0, 1, 0));
        nextCycle();
        wr_req = 1'b0;
        checkOutput("wr_after_fill_idle", zero);

        // Reset, then both fills held: D first, then I, D, I.
        nextCycle();
        rst = 1'b1;
        checkOutput("contend_rst", zero);
        nextCycle();
        rst    = 1'b0;
        i_base = 16'h0100;
        i_cnt  = 0;
        d_base = 16'h0200;
        d_cnt  = 0;
        i_addr = i_base;
        d_addr = d_base;
        i_req  = 1'b1;
        d_req  = 1'b1;
        checkOutput("contend_bubble", zero);
        runFill(1'b1, 1, 1'b0, 1'b1);
        runFill(1'b0, 1, 1'b0, 1'b1);
        runFill(1'b1, 2, 1'b0, 1'b0);
        runFill(1'b0, 1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("final_idle", zero);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single multi-cycle main-memory port between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores. Sits directly downstream of both fill FSMs: it forwards the granted requester's memory address and read enable to memory, and routes the returning data-valid strobe back only to that requester. A grant is held for a complete 8-word block fill, so a fill FSM never sees beats belonging to the other cache.

## Interface
- `ADDR_W`, default 16, address width
- `DATA_W`, default 16, data word width
- `BEATS`, default 8, words per block fill; must be a power of two
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `i_req` in 1: I-cache fill request; the I-fill FSM's busy output.
- `i_addr` in ADDR_W: the I-fill FSM's memory address.
- `d_req` in 1: D-cache fill request; the D-fill FSM's busy output.
- `d_addr` in ADDR_W: the D-fill FSM's memory address.
- `wr_req` in 1: D-cache write-through store request.
- `wr_addr` in ADDR_W: store address.
- `wr_data` in DATA_W: store data.
- `mem_en` out 1: memory access enable.
- `mem_wr` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_valid` in 1: memory read data valid.
- `i_valid` out 1: data-valid to the I-fill FSM.
- `d_valid` out 1: data-valid to the D-fill FSM.
- `wr_ack` out 1: store accepted, one-cycle pulse.
- `wr_stall` out 1: store pending but not yet accepted.

## Operation
- States: IDLE, I_FILL, D_FILL, WRITE. The state register is the only control state. A 3-bit beat counter (`$clog2(BEATS)`) and a one-bit `last_fill_was_d` flag complete it.
- **IDLE**
  - All memory outputs are 0.
  - Priority: `wr_req` → WRITE.
  - Else, if both fills request: go to I_FILL when `last_fill_was_d`=1, otherwise D_FILL.
  - Else, a single fill request goes to its own state.
  - Else, stay in IDLE.
- **WRITE**, lasts exactly one cycle:
  - `mem_en`=1, `mem_wr`=1, `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`, `wr_ack`=1.
  - Next state is IDLE.
- **I_FILL / D_FILL**
  - `mem_en`=1, `mem_wr`=0.
  - `mem_addr` = the granted requester's address, combinational pass-through.
  - The granted `*_valid` output = `mem_valid`; the other is 0.
  - The beat counter clears on entry and increments on each `mem_valid`.
  - On the `mem_valid` that is beat BEATS-1: return to IDLE on that edge and update `last_fill_was_d`.
- `mem_wdata` is 0 whenever `mem_wr`=0.
- `wr_stall` = `wr_req` & ~`wr_ack`.
- A grant is never preempted. Writes wait for the fill to finish.
- Requester deasserts its request mid-fill: the arbiter still completes the BEATS beats. This is a protocol violation by the requester and is not checked.
- `mem_valid` in IDLE or WRITE is dropped: both `*_valid` are 0.

## Timing
- Reset (synchronous, `rst`=1 at an edge):
  - State → IDLE, beat counter → 0, `last_fill_was_d` → 0.
  - All outputs are 0 in the following cycle.
  - Reset mid-fill abandons the fill. Late `mem_valid` beats are then dropped.
- Grant latency:
  - Request sampled in IDLE at edge N.
  - Grant state active, with `mem_en`=1, from cycle N+1.
  - Minimum 1 cycle of arbitration bubble per transaction.
- Data path latency:
  - `mem_valid` → `i_valid`/`d_valid` is combinational, 0 cycles.
  - `mem_addr` follows the requester's address combinationally, so a fill FSM's address increment on beat k appears on `mem_addr` in the next cycle.
- Simultaneous `wr_req` and both fill requests in IDLE → WRITE first. The fills then arbitrate from IDLE in the cycle after the WRITE.
- Back-to-back:
  - The final beat returns the arbiter to IDLE, so the next grant starts 1 cycle later.
  - Total occupancy per fill = BEATS × memory latency + 1 IDLE cycle.

## Structure
- Shared package:
  - state enum: `ARB_IDLE`, `ARB_I_FILL`, `ARB_D_FILL`, `ARB_WRITE`
  - `BLOCK_BEATS` = 8
  - `MEM_ADDR_W` / `MEM_DATA_W` = 16
- One sub-module: `beat_counter`, a synchronous clear/increment counter with a terminal-count output. It is reusable by the fill FSMs.
- Output muxing is combinational from the state register. No registered outputs.

## Test plan
- Single I-fill:
  - Stimulus: `i_req`=1, `i_addr`=0x0040; memory returns 8 beats at 4-cycle spacing.
  - Required: `mem_en`=1 from cycle 1; 8 `i_valid` pulses; `d_valid` never asserted; IDLE after beat 8.
- Contention round-robin:
  - Stimulus: `i_req` and `d_req` both held from reset.
  - Required: D_FILL first (flag=0); I_FILL next; then D_FILL; each grant exactly 8 beats.
- Write priority:
  - Stimulus: `wr_req`=1, `wr_addr`=0x1234, `wr_data`=0xBEEF, asserted with `d_req` in IDLE.
  - Required: one WRITE cycle with `mem_wr`=1, addr 0x1234, data 0xBEEF, `wr_ack`=1; then D_FILL.
- Write during fill:
  - Stimulus: `wr_req` raised at beat 3 of an I-fill.
  - Required: `wr_stall`=1 until the cycle after beat 8; then one WRITE with `wr_ack`.
- Reset mid-fill:
  - Stimulus: `rst` after beat 4 of a D-fill, then 2 stray `mem_valid` pulses.
  - Required: all outputs 0; stray beats not routed; the next `d_req` is granted with the beat count starting at 0.
- Stray valid:
  - Stimulus: `mem_valid`=1 in IDLE.
  - Required: `i_valid` = `d_valid` = 0; state unchanged.
